// File: rtl/trade_order_if.sv
// Order request channel from trade_order_gen to the order serialiser.
// The generator drives the order fields; the serialiser returns order_ready.
interface trade_order_if;
  logic       order_valid;
  logic       order_ready;
  logic       order_side;
  logic [7:0] order_price;
  logic [7:0] order_id;

  modport master (
    output order_valid,
    output order_side,
    output order_price,
    output order_id,
    input  order_ready
  );

  modport slave (
    input  order_valid,
    input  order_side,
    input  order_price,
    input  order_id,
    output order_ready
  );
endinterface

// File: rtl/trade_order_gen.sv
// Turns buy/sell signal levels into single in-flight order requests, with
// a net-position limit, post-order cooldown, sequence IDs and a drop counter.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | evaluating buy/sell; may create an order or count a drop
// ISSUE    | order presented, waiting for order_ready
// COOLDOWN | post-order quiet time, inputs ignored
module trade_order_gen #(
  parameter int MAX_POSITION    = 4,
  parameter int COOLDOWN_CYCLES = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         buy_signal,
  input  logic         sell_signal,
  input  logic [7:0]   price,
  trade_order_if.master ord,
  output logic [3:0]   position,
  output logic         busy,
  output logic [7:0]   drop_count
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_ISSUE    = 2'd1,
    S_COOLDOWN = 2'd2
  } state_t;

  localparam logic [3:0] POS_MAX = 4'(MAX_POSITION);
  localparam logic [3:0] POS_MIN = 4'(-MAX_POSITION);
  localparam logic [7:0] CD_LOAD = 8'(COOLDOWN_CYCLES);
  localparam bit         HAS_CD  = (COOLDOWN_CYCLES > 0);

  state_t     state;
  logic [7:0] cd_cnt;
  logic       valid_q;
  logic       side_q;
  logic [7:0] price_q;
  logic [7:0] id_q;
  logic       reject;
  logic [7:0] drop_next;

  // A request is rejected on conflict or when it would push past the limit.
  always_comb begin
    reject = 1'b0;
    if (buy_signal && sell_signal)
      reject = 1'b1;
    else if (buy_signal && (position == POS_MAX))
      reject = 1'b1;
    else if (sell_signal && (position == POS_MIN))
      reject = 1'b1;
    drop_next = (drop_count == 8'hFF) ? drop_count : drop_count + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      cd_cnt     <= 8'd0;
      valid_q    <= 1'b0;
      side_q     <= 1'b0;
      price_q    <= 8'd0;
      id_q       <= 8'd0;
      position   <= 4'd0;
      drop_count <= 8'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (reject) begin
            drop_count <= drop_next;
          end else if (buy_signal || sell_signal) begin
            side_q  <= buy_signal;
            price_q <= price;
            valid_q <= 1'b1;
            state   <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (ord.order_ready) begin
            valid_q  <= 1'b0;
            position <= side_q ? position + 4'd1 : position - 4'd1;
            id_q     <= id_q + 8'd1;
            if (HAS_CD) begin
              cd_cnt <= CD_LOAD;
              state  <= S_COOLDOWN;
            end else begin
              state  <= S_IDLE;
            end
          end
        end
        S_COOLDOWN: begin
          // Leaving on the 1->0 step keeps COOLDOWN exactly CD_LOAD cycles long.
          cd_cnt <= cd_cnt - 8'd1;
          if (cd_cnt == 8'd1)
            state <= S_IDLE;
        end
        default: begin
          state   <= S_IDLE;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign ord.order_valid = valid_q;
  assign ord.order_side  = side_q;
  assign ord.order_price = price_q;
  assign ord.order_id    = id_q;
  assign busy            = (state != S_IDLE);

endmodule
